// File: rtl/fetch_execute.sv
`default_nettype none
// ============================================================================
// Module   : fetch_execute
// Purpose  : Two-cycle FETCH/EXECUTE sequencer and A/B datapath for the
//            accumulator CPU; addresses the instruction ROM and consumes it.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_execute #(
    parameter int COUNTER_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int OPCODE_WIDTH  = 3
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                run,
    input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0]  instruction,
    output logic [COUNTER_WIDTH-1:0]            count,
    output logic [DATA_WIDTH-1:0]               acc,
    output logic [DATA_WIDTH-1:0]               breg,
    output logic                                carry,
    output logic                                illegal,
    output logic                                executing
);

    localparam int INSTRUCTION_WIDTH = OPCODE_WIDTH + DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] c_op_nop   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] c_op_loadi = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] c_op_move  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] c_op_add   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] c_op_reset = OPCODE_WIDTH'(4);

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_EXECUTE = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [INSTRUCTION_WIDTH-1:0]   r_ir;
    logic [INSTRUCTION_WIDTH-1:0]   w_ir_next;
    logic [COUNTER_WIDTH-1:0]       r_count;
    logic [COUNTER_WIDTH-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0]          r_acc;
    logic [DATA_WIDTH-1:0]          w_acc_next;
    logic [DATA_WIDTH-1:0]          r_breg;
    logic [DATA_WIDTH-1:0]          w_breg_next;
    logic                           r_carry;
    logic                           w_carry_next;
    logic                           r_illegal;
    logic                           w_illegal_next;

    logic [OPCODE_WIDTH-1:0]        w_opcode;
    logic [DATA_WIDTH-1:0]          w_operand;
    logic [DATA_WIDTH:0]            w_sum;

    assign w_opcode  = r_ir[INSTRUCTION_WIDTH-1:DATA_WIDTH];
    assign w_operand = r_ir[DATA_WIDTH-1:0];
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_breg};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ir_next      = r_ir;
        w_count_next   = r_count;
        w_acc_next     = r_acc;
        w_breg_next    = r_breg;
        w_carry_next   = r_carry;
        w_illegal_next = r_illegal;
        case (r_state)
            ST_FETCH: begin
                if (run) begin
                    w_ir_next    = instruction;
                    w_state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                // The in-flight instruction always retires, regardless of run.
                w_state_next = ST_FETCH;
                w_count_next = r_count + COUNTER_WIDTH'(1);
                case (w_opcode)
                    c_op_nop:   ;
                    c_op_loadi: w_acc_next  = w_operand;
                    c_op_move:  w_breg_next = r_acc;
                    c_op_add: begin
                        w_acc_next   = w_sum[DATA_WIDTH-1:0];
                        w_carry_next = w_sum[DATA_WIDTH];
                    end
                    c_op_reset: begin
                        w_acc_next   = '0;
                        w_breg_next  = '0;
                        w_carry_next = 1'b0;
                    end
                    default:    w_illegal_next = 1'b1;
                endcase
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir      <= '0;
            r_count   <= COUNTER_WIDTH'(1);
            r_acc     <= '0;
            r_breg    <= '0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ir      <= w_ir_next;
            r_count   <= w_count_next;
            r_acc     <= w_acc_next;
            r_breg    <= w_breg_next;
            r_carry   <= w_carry_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign count     = r_count;
    assign acc       = r_acc;
    assign breg      = r_breg;
    assign carry     = r_carry;
    assign illegal   = r_illegal;
    assign executing = (r_state == ST_EXECUTE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_execute
// Purpose  : Directed self-checking bench for fetch_execute with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_execute;

    logic        clock;
    logic        reset;
    logic        run;
    logic [10:0] instruction;
    logic [3:0]  count;
    logic [7:0]  acc;
    logic [7:0]  breg;
    logic        carry;
    logic        illegal;
    logic        executing;

    logic [10:0] rom [16];

    int checks   = 0;
    int failures = 0;

    fetch_execute #(
        .COUNTER_WIDTH (4),
        .DATA_WIDTH    (8),
        .OPCODE_WIDTH  (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .count       (count),
        .acc         (acc),
        .breg        (breg),
        .carry       (carry),
        .illegal     (illegal),
        .executing   (executing)
    );

    assign instruction = rom[count];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 11'h000;
    endtask

    // Pulse reset away from any clock edge, leaving run low.
    task automatic pulse_reset();
        run   = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        clear_rom();
        #2;

        // Reset state
        check("rst_count", count, 4'd1);
        check("rst_acc", acc, 8'd0);
        check("rst_breg", breg, 8'd0);
        check("rst_carry", carry, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_exec", executing, 1'b0);
        reset = 1'b0;

        // Program run
        rom[1] = {3'd1, 8'd3};
        rom[2] = {3'd2, 8'd0};
        rom[3] = {3'd1, 8'd1};
        rom[4] = {3'd3, 8'd0};
        rom[5] = {3'd4, 8'd0};
        rom[6] = {3'd1, 8'd1};
        rom[7] = {3'd3, 8'd0};
        rom[8] = {3'd4, 8'd0};
        run = 1'b1;
        cycles(1);
        check("prog_exec_hi", executing, 1'b1);
        check("prog_count_fetch", count, 4'd1);
        cycles(1);
        check("prog_i1_acc", acc, 8'd3);
        check("prog_i1_count", count, 4'd2);
        check("prog_exec_lo", executing, 1'b0);
        cycles(6);
        check("prog_i4_acc", acc, 8'd4);
        check("prog_i4_breg", breg, 8'd3);
        check("prog_i4_carry", carry, 1'b0);
        cycles(2);
        check("prog_i5_acc", acc, 8'd0);
        check("prog_i5_breg", breg, 8'd0);
        cycles(4);
        check("prog_i7_acc", acc, 8'd1);
        cycles(2);
        check("prog_end_acc", acc, 8'd0);
        check("prog_end_breg", breg, 8'd0);
        check("prog_end_count", count, 4'd9);

        // Carry
        pulse_reset();
        clear_rom();
        rom[1] = {3'd1, 8'hFF};
        rom[2] = {3'd2, 8'h00};
        rom[3] = {3'd1, 8'h02};
        rom[4] = {3'd3, 8'h00};
        rom[5] = {3'd1, 8'h05};
        run = 1'b1;
        cycles(8);
        check("carry_add_acc", acc, 8'h01);
        check("carry_add_c", carry, 1'b1);
        check("carry_add_breg", breg, 8'hFF);
        cycles(2);
        check("carry_loadi_acc", acc, 8'h05);
        check("carry_loadi_c", carry, 1'b1);

        // Wrap-around over an all-NOP ROM
        pulse_reset();
        clear_rom();
        run = 1'b1;
        cycles(28);
        check("wrap_count15", count, 4'd15);
        cycles(2);
        check("wrap_count0", count, 4'd0);
        cycles(2);
        check("wrap_count1", count, 4'd1);
        check("wrap_acc", acc, 8'd0);
        check("wrap_breg", breg, 8'd0);
        check("wrap_illegal", illegal, 1'b0);

        // Illegal opcode
        pulse_reset();
        clear_rom();
        rom[1] = {3'd1, 8'h09};
        rom[2] = {3'd2, 8'h00};
        rom[3] = {3'd6, 8'h55};
        rom[4] = {3'd4, 8'h00};
        run = 1'b1;
        cycles(4);
        check("ill_before", illegal, 1'b0);
        cycles(2);
        check("ill_set", illegal, 1'b1);
        check("ill_count", count, 4'd4);
        check("ill_acc", acc, 8'h09);
        check("ill_breg", breg, 8'h09);
        cycles(2);
        check("ill_after_rst_op", illegal, 1'b1);
        check("ill_rst_op_acc", acc, 8'h00);
        pulse_reset();
        check("ill_cleared", illegal, 1'b0);

        // Run gating
        clear_rom();
        rom[1] = {3'd1, 8'd7};
        rom[2] = {3'd1, 8'd8};
        run = 1'b1;
        cycles(1);
        check("gate_exec", executing, 1'b1);
        run = 1'b0;
        cycles(1);
        check("gate_acc", acc, 8'd7);
        check("gate_count", count, 4'd2);
        check("gate_exec_lo", executing, 1'b0);
        cycles(10);
        check("gate_hold_count", count, 4'd2);
        check("gate_hold_exec", executing, 1'b0);
        check("gate_hold_acc", acc, 8'd7);
        run = 1'b1;
        cycles(1);
        check("gate_resume_exec", executing, 1'b1);
        cycles(1);
        check("gate_resume_acc", acc, 8'd8);
        check("gate_resume_count", count, 4'd3);

        // Asynchronous reset mid-EXECUTE of ADD
        pulse_reset();
        clear_rom();
        rom[1] = {3'd1, 8'd3};
        rom[2] = {3'd2, 8'd0};
        rom[3] = {3'd3, 8'd0};
        run = 1'b1;
        cycles(4);
        check("async_pre_acc", acc, 8'd3);
        check("async_pre_breg", breg, 8'd3);
        cycles(1);
        check("async_pre_exec", executing, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_acc", acc, 8'd0);
        check("async_breg", breg, 8'd0);
        check("async_carry", carry, 1'b0);
        check("async_count", count, 4'd1);
        check("async_exec", executing, 1'b0);
        cycles(1);
        check("async_hold_acc", acc, 8'd0);
        reset = 1'b0;
        run   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
